// File: rtl/tx_link_pkg.sv
// rtl/tx_link_pkg.sv - shared control codes, state encoding and encoder symbol type
package tx_link_pkg;

   localparam logic [7:0] K_COMMA = 8'hBC;
   localparam logic [7:0] K_SOF   = 8'hFB;
   localparam logic [7:0] K_EOF   = 8'hFD;
   localparam logic [7:0] K_FILL  = 8'hF7;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_IDLE,
      ST_SOF,
      ST_DATA,
      ST_EOF,
      ST_DROP
   } link_state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       k;
   } enc_sym_t;

   function automatic enc_sym_t ctrl_sym(input logic [7:0] code);
      return '{data: code, k: 1'b1};
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tx_link_ctrl.sv
// rtl/tx_link_ctrl.sv - transmit sequencer feeding one symbol per clock to the 8b/10b encoder
module tx_link_ctrl
   import tx_link_pkg::*;
#(
   parameter int SYNC_LEN  = 16,
   parameter int IDLE_MIN  = 2,
   parameter int MAX_FRAME = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] enc_data,
   output logic       enc_k,
   output logic       link_up,
   output logic       frame_err
);

   localparam int CW = $clog2(max_int(SYNC_LEN, IDLE_MIN)) + 1;
   localparam int BW = $clog2(MAX_FRAME) + 1;
   localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_MIN - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(MAX_FRAME - 1);

   link_state_t   state;
   logic [CW-1:0] cnt;
   logic [BW-1:0] byte_cnt;
   logic          trunc;
   enc_sym_t      sym;
   logic          xfer;

   assign s_ready  = (state == ST_DATA) || (state == ST_DROP);
   assign xfer     = s_valid && s_ready;
   assign enc_data = sym.data;
   assign enc_k    = sym.k;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_SYNC;
         cnt       <= '0;
         byte_cnt  <= '0;
         trunc     <= 1'b0;
         sym       <= ctrl_sym(K_COMMA);
         link_up   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            ST_SYNC: begin
               sym <= ctrl_sym(K_COMMA);
               if (cnt == SYNC_LAST) begin
                  state   <= ST_IDLE;
                  cnt     <= '0;
                  link_up <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_IDLE: begin
               sym <= ctrl_sym(K_COMMA);
               if (cnt != {CW{1'b1}})
                  cnt <= cnt + CW'(1);
               // The waiting byte is only a start request; DATA consumes it.
               if (s_valid && (cnt >= IDLE_LAST))
                  state <= ST_SOF;
            end
            ST_SOF: begin
               sym      <= ctrl_sym(K_SOF);
               state    <= ST_DATA;
               byte_cnt <= '0;
            end
            ST_DATA: begin
               if (xfer) begin
                  sym      <= '{data: s_data, k: 1'b0};
                  byte_cnt <= byte_cnt + BW'(1);
                  if (s_last) begin
                     state <= ST_EOF;
                     trunc <= 1'b0;
                  end else if (byte_cnt == BYTE_LAST) begin
                     state     <= ST_EOF;
                     trunc     <= 1'b1;
                     frame_err <= 1'b1;
                  end
               end else begin
                  sym <= ctrl_sym(K_FILL);
               end
            end
            ST_EOF: begin
               sym   <= ctrl_sym(K_EOF);
               cnt   <= '0;
               state <= trunc ? ST_DROP : ST_IDLE;
            end
            ST_DROP: begin
               sym <= ctrl_sym(K_COMMA);
               if (xfer && s_last) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               sym   <= ctrl_sym(K_COMMA);
               state <= ST_SYNC;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
